lifm_partition_loader: RTL and testbench
========================================

// Module: lifm_partition_loader
// PURPOSE
//  Stage directly upstream of the redundancy controller. Accepts a word-serial LIFM stream,
//  assembles STEP_RANGE-word columns into a partition of rsiz rows plus one kernel index
//  per row, then launches the controller and drives the rows on consecutive cycles.
//  Blocks new input until the controller reports completion (rc_done).
// PARAMETERS
//  WORD_WIDTH     8    bitwidth of activation word and kernel index
//  RSIZ_WIDTH     2    bitwidth of partition row-size field
//  MAX_LIFM_RSIZ  3    maximum rows per partition (row-buffer depth)
//  STEP_RANGE     128  words per LIFM column (column window size)
// PORTS
//  clk             in   1                     positive-edge clock
//  reset_n         in   1                     asynchronous active-low reset
//  rsiz            in   RSIZ_WIDTH            partition row count, sampled on first accepted word
//  word_valid      in   1                     ingress word valid
//  word_ready      out  1                     ingress ready; transfer when valid&&ready
//  word_data       in   WORD_WIDTH            LIFM element; element 0 of column first
//  word_kidx       in   WORD_WIDTH            kernel index, sampled with element 0 of each row
//  rc_enable       out  1                     one-cycle launch pulse to controller enable_in
//  rc_rsiz         out  RSIZ_WIDTH            effective row count of current partition
//  rc_kidx         out  WORD_WIDTH            kernel index of row being driven
//  rc_lifm_column  out  WORD_WIDTH*STEP_RANGE row being driven; element i at [i*WORD_WIDTH +: WORD_WIDTH]
//  rc_done         in   1                     controller finished partition (its valid output)
//  busy            out  1                     high in any state except IDLE
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; counters, row buffer, kidx buffer cleared. Reset mid-op aborts partition.
//  States: IDLE -> FILL -> LAUNCH -> DRIVE -> WAIT_DONE -> IDLE.
//  IDLE: word_ready=1. First transfer latches eff_rsiz, stores word as row0/elem0 and kidx0 -> FILL.
//   eff_rsiz = 2 if rsiz<2; MAX_LIFM_RSIZ if rsiz>MAX_LIFM_RSIZ; else rsiz.
//  FILL: word_ready=1. elem_cnt 0..STEP_RANGE-1, wraps to 0 and row_cnt++ after STEP_RANGE-1.
//   kidx stored on elem_cnt==0 transfers only. Transfer of last elem of row eff_rsiz-1 -> LAUNCH.
//   Cycles with word_valid=0 hold all counters.
//  LAUNCH: word_ready=0; rc_enable=1 for exactly this cycle; rc_rsiz valid from here until IDLE.
//  DRIVE: rows driven oldest-first, one per cycle, row0 in first DRIVE cycle; after row eff_rsiz-1
//   the last row is held one extra cycle (eff_rsiz+1 DRIVE cycles total) -> WAIT_DONE.
//  WAIT_DONE: rc_kidx/rc_lifm_column hold last row; word_ready=0; rc_done=1 -> IDLE (ready next cycle).
//  rc_done outside WAIT_DONE ignored. rc_enable never asserted outside LAUNCH.
//  rc_rsiz, rc_kidx, rc_lifm_column are registered; 0 in IDLE.
//  Latency: last accepted word -> rc_enable 1 cycle; rc_enable -> row0 on outputs 1 cycle.
//  Counters: elem_cnt $clog2(STEP_RANGE) bits, row_cnt $clog2(MAX_LIFM_RSIZ+1) bits, no overflow by construction.
// STRUCTURE
//  Shared package: state encoding localparams (LPL_IDLE..LPL_WAIT_DONE), eff_rsiz clamp function.
//  One sub-module: lifm_column_assembler (word-serial -> STEP_RANGE-wide register, write-enable by elem_cnt).
//  Row buffer MAX_LIFM_RSIZ x column and kidx buffer in top level; FSM in top level.
// TESTING (bench uses STEP_RANGE=4, WORD_WIDTH=8)
//  rsiz=2, 8 words 0x01..0x08 back-to-back, kidx 5,9 -> rc_enable 1 cycle after word 8; row0=
//   {04,03,02,01} kidx5, then row1={08,07,06,05} kidx9 held 2 cycles; word_ready=0 until rc_done.
//  rsiz=3 with word_valid toggled every other cycle -> same column packing, 12 transfers, 3 rows + 1 hold.
//  rsiz=0 and rsiz=1 -> eff_rsiz=2, rc_rsiz=2, 8 words consumed before rc_enable.
//  rc_done pulsed during FILL and DRIVE -> ignored; pulse in WAIT_DONE -> IDLE, busy=0, word_ready=1 next cycle.
//  reset_n low in DRIVE -> all outputs 0 immediately; new partition afterwards packs from elem 0.
//  Two partitions back-to-back (rc_done 3 cycles after drive) -> second kidx/data never mixes with first.

Source files
------------

// File: rtl/lifm_partition_loader_pkg.sv
// Shared definitions for the LIFM partition loader: FSM encoding and row-count clamp.
package lifm_partition_loader_pkg;

  localparam logic [2:0] LPL_IDLE      = 3'd0;
  localparam logic [2:0] LPL_FILL      = 3'd1;
  localparam logic [2:0] LPL_LAUNCH    = 3'd2;
  localparam logic [2:0] LPL_DRIVE     = 3'd3;
  localparam logic [2:0] LPL_WAIT_DONE = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE      = LPL_IDLE,
    ST_FILL      = LPL_FILL,
    ST_LAUNCH    = LPL_LAUNCH,
    ST_DRIVE     = LPL_DRIVE,
    ST_WAIT_DONE = LPL_WAIT_DONE
  } lpl_state_e;

  // The controller needs at least two rows and the row buffer holds at most max_rsiz.
  function automatic int unsigned lpl_eff_rsiz(input int unsigned rsiz, input int unsigned max_rsiz);
    if (rsiz < 2) return 2;
    if (rsiz > max_rsiz) return max_rsiz;
    return rsiz;
  endfunction

endpackage

// File: rtl/lifm_partition_loader_if.sv
// Ingress word stream plus controller launch/drive bus of the LIFM partition loader.
interface lifm_partition_loader_if #(
  parameter int WORD_WIDTH = 8,
  parameter int RSIZ_WIDTH = 2,
  parameter int STEP_RANGE = 128
);
  logic [RSIZ_WIDTH-1:0]            rsiz;
  logic                             word_valid;
  logic                             word_ready;
  logic [WORD_WIDTH-1:0]            word_data;
  logic [WORD_WIDTH-1:0]            word_kidx;
  logic                             rc_enable;
  logic [RSIZ_WIDTH-1:0]            rc_rsiz;
  logic [WORD_WIDTH-1:0]            rc_kidx;
  logic [WORD_WIDTH*STEP_RANGE-1:0] rc_lifm_column;
  logic                             rc_done;

  modport master (
    output rsiz, word_valid, word_data, word_kidx, rc_done,
    input  word_ready, rc_enable, rc_rsiz, rc_kidx, rc_lifm_column
  );

  modport slave (
    input  rsiz, word_valid, word_data, word_kidx, rc_done,
    output word_ready, rc_enable, rc_rsiz, rc_kidx, rc_lifm_column
  );
endinterface

// File: rtl/lifm_partition_loader_column_assembler.sv
// Packs a word-serial stream into one STEP_RANGE-wide column register, element i at [i*W +: W].
module lifm_column_assembler #(
  parameter int WORD_WIDTH = 8,
  parameter int STEP_RANGE = 128,
  parameter int ELEM_W     = $clog2(STEP_RANGE)
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             wr_en,
  input  logic [ELEM_W-1:0]                elem_idx,
  input  logic [WORD_WIDTH-1:0]            word,
  output logic [WORD_WIDTH*STEP_RANGE-1:0] column_q,
  output logic [WORD_WIDTH*STEP_RANGE-1:0] column_d
);

  // column_d already contains the incoming word, so the last element can be committed same-cycle.
  for (genvar gi = 0; gi < STEP_RANGE; gi++) begin : g_elem
    assign column_d[gi*WORD_WIDTH +: WORD_WIDTH] =
      (wr_en && (elem_idx == ELEM_W'(gi))) ? word : column_q[gi*WORD_WIDTH +: WORD_WIDTH];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) column_q <= '0;
    else          column_q <= column_d;
  end

endmodule

// File: rtl/lifm_partition_loader.sv
// Collects a partition of LIFM rows plus kernel indices, launches the redundancy controller and drives the rows.
module lifm_partition_loader
  import lifm_partition_loader_pkg::*;
#(
  parameter int WORD_WIDTH    = 8,
  parameter int RSIZ_WIDTH    = 2,
  parameter int MAX_LIFM_RSIZ = 3,
  parameter int STEP_RANGE    = 128
) (
  input  logic                      clk,
  input  logic                      reset_n,
  lifm_partition_loader_if.slave    bus,
  output logic                      busy
);

  localparam int ELEM_W = $clog2(STEP_RANGE);
  localparam int ROW_W  = $clog2(MAX_LIFM_RSIZ + 1);
  localparam int COL_W  = WORD_WIDTH * STEP_RANGE;

  lpl_state_e              state_q, state_d;
  logic [ELEM_W-1:0]       elem_cnt_q, elem_cnt_d;
  logic [ROW_W-1:0]        row_cnt_q, row_cnt_d;
  logic [RSIZ_WIDTH-1:0]   eff_rsiz_q, eff_rsiz_d;
  logic                    word_ready_q, word_ready_d;
  logic [RSIZ_WIDTH-1:0]   rc_rsiz_q, rc_rsiz_d;
  logic [WORD_WIDTH-1:0]   rc_kidx_q, rc_kidx_d;
  logic [COL_W-1:0]        rc_col_q, rc_col_d;
  logic [COL_W-1:0]        row_buf_q [MAX_LIFM_RSIZ];
  logic [WORD_WIDTH-1:0]   kidx_buf_q [MAX_LIFM_RSIZ];

  logic                    xfer, kidx_wr, row_wr;
  logic [ROW_W-1:0]        eff_row, next_row;
  logic [ROW_W:0]          row_inc;
  logic [COL_W-1:0]        asm_col_q, asm_col_d;

  assign xfer    = bus.word_valid && word_ready_q;
  assign eff_row = ROW_W'(eff_rsiz_q);
  assign row_inc = {1'b0, row_cnt_q} + 1'b1;

  lifm_column_assembler #(
    .WORD_WIDTH(WORD_WIDTH),
    .STEP_RANGE(STEP_RANGE),
    .ELEM_W    (ELEM_W)
  ) u_asm (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (xfer),
    .elem_idx(elem_cnt_q),
    .word    (bus.word_data),
    .column_q(asm_col_q),
    .column_d(asm_col_d)
  );

  always_comb begin
    state_d    = state_q;
    elem_cnt_d = elem_cnt_q;
    row_cnt_d  = row_cnt_q;
    eff_rsiz_d = eff_rsiz_q;
    kidx_wr    = 1'b0;
    row_wr     = 1'b0;
    unique case (state_q)
      ST_IDLE: if (xfer) begin
        eff_rsiz_d = RSIZ_WIDTH'(lpl_eff_rsiz(int'(bus.rsiz), MAX_LIFM_RSIZ));
        kidx_wr    = 1'b1;
        elem_cnt_d = ELEM_W'(1);
        row_cnt_d  = '0;
        state_d    = ST_FILL;
      end
      ST_FILL: if (xfer) begin
        kidx_wr = (elem_cnt_q == '0);
        if (elem_cnt_q == ELEM_W'(STEP_RANGE - 1)) begin
          row_wr     = 1'b1;
          elem_cnt_d = '0;
          if (row_cnt_q == eff_row - 1'b1) begin
            row_cnt_d = '0;
            state_d   = ST_LAUNCH;
          end else begin
            row_cnt_d = row_inc[ROW_W-1:0];
          end
        end else begin
          elem_cnt_d = elem_cnt_q + 1'b1;
        end
      end
      ST_LAUNCH: begin
        row_cnt_d = '0;
        state_d   = ST_DRIVE;
      end
      // row_cnt counts DRIVE cycles; the count reaching eff_row marks the extra hold cycle.
      ST_DRIVE: begin
        if (row_cnt_q == eff_row) begin
          row_cnt_d = '0;
          state_d   = ST_WAIT_DONE;
        end else begin
          row_cnt_d = row_inc[ROW_W-1:0];
        end
      end
      ST_WAIT_DONE: if (bus.rc_done) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    next_row = '0;
    if (state_q == ST_DRIVE)
      next_row = (row_inc >= {1'b0, eff_row}) ? eff_row - 1'b1 : row_inc[ROW_W-1:0];
    word_ready_d = (state_d == ST_IDLE) || (state_d == ST_FILL);
    rc_rsiz_d    = word_ready_d ? '0 : eff_rsiz_d;
    rc_kidx_d    = rc_kidx_q;
    rc_col_d     = rc_col_q;
    if (word_ready_d) begin
      rc_kidx_d = '0;
      rc_col_d  = '0;
    end else if (state_q == ST_LAUNCH || (state_q == ST_DRIVE && state_d == ST_DRIVE)) begin
      rc_kidx_d = kidx_buf_q[next_row];
      rc_col_d  = row_buf_q[next_row];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      elem_cnt_q   <= '0;
      row_cnt_q    <= '0;
      eff_rsiz_q   <= '0;
      word_ready_q <= 1'b0;
      rc_rsiz_q    <= '0;
      rc_kidx_q    <= '0;
      rc_col_q     <= '0;
      for (int i = 0; i < MAX_LIFM_RSIZ; i++) begin
        row_buf_q[i]  <= '0;
        kidx_buf_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      elem_cnt_q   <= elem_cnt_d;
      row_cnt_q    <= row_cnt_d;
      eff_rsiz_q   <= eff_rsiz_d;
      word_ready_q <= word_ready_d;
      rc_rsiz_q    <= rc_rsiz_d;
      rc_kidx_q    <= rc_kidx_d;
      rc_col_q     <= rc_col_d;
      if (kidx_wr) kidx_buf_q[row_cnt_q] <= bus.word_kidx;
      if (row_wr)  row_buf_q[row_cnt_q]  <= asm_col_d;
    end
  end

  assign bus.word_ready     = word_ready_q;
  assign bus.rc_enable      = (state_q == ST_LAUNCH);
  assign bus.rc_rsiz        = rc_rsiz_q;
  assign bus.rc_kidx        = rc_kidx_q;
  assign bus.rc_lifm_column = rc_col_q;
  assign busy               = (state_q != ST_IDLE);

endmodule

// File: tb/tb_lifm_partition_loader.sv
// Directed self-checking bench for lifm_partition_loader with 4-word columns.
module tb_lifm_partition_loader;

  localparam int WW  = 8;
  localparam int RW  = 2;
  localparam int MAX = 3;
  localparam int SR  = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic busy;
  int   n_checks = 0;
  int   n_errors = 0;

  lifm_partition_loader_if #(.WORD_WIDTH(WW), .RSIZ_WIDTH(RW), .STEP_RANGE(SR)) bus ();

  lifm_partition_loader #(
    .WORD_WIDTH(WW), .RSIZ_WIDTH(RW), .MAX_LIFM_RSIZ(MAX), .STEP_RANGE(SR)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus.slave),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference column of a row when words base, base+1, ... are streamed in order.
  function automatic logic [31:0] col_of(input logic [7:0] base, input int row);
    logic [31:0] c;
    for (int e = 0; e < SR; e++) c[e*8 +: 8] = base + 8'(row*SR + e);
    return c;
  endfunction

  task automatic check_idle(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_ready"}, 64'(bus.word_ready), 64'd1);
    chk({tag, "_rsiz"}, 64'(bus.rc_rsiz), 64'd0);
    chk({tag, "_kidx"}, 64'(bus.rc_kidx), 64'd0);
    chk({tag, "_col"}, 64'(bus.rc_lifm_column), 64'd0);
  endtask

  // Streams n words; kidx is only meaningful on element 0, other words carry 0xEE.
  task automatic feed(input int n, input logic [7:0] base, input logic [1:0] rsz, input int eff,
                      input logic [23:0] kv, input bit toggle, input bit done_pulse);
    for (int i = 0; i < n; i++) begin
      if (toggle && i > 0) begin
        @(negedge clk);
        bus.word_valid = 1'b0;
        bus.word_data  = 8'hAA;
        bus.rc_done    = done_pulse;
      end
      @(negedge clk);
      bus.rc_done    = 1'b0;
      bus.rsiz       = (i == 0) ? rsz : ~rsz;
      bus.word_valid = 1'b1;
      bus.word_data  = base + 8'(i);
      bus.word_kidx  = (i % SR == 0) ? kv[(i/SR)*8 +: 8] : 8'hEE;
      chk("fill_ready", 64'(bus.word_ready), 64'd1);
      chk("fill_no_enable", 64'(bus.rc_enable), 64'd0);
    end
    @(negedge clk);
    bus.word_valid = 1'b0;
    chk("launch_enable", 64'(bus.rc_enable), 64'd1);
    chk("launch_rsiz", 64'(bus.rc_rsiz), 64'(eff));
    chk("launch_ready", 64'(bus.word_ready), 64'd0);
    chk("launch_busy", 64'(busy), 64'd1);
  endtask

  task automatic drive(input int eff, input logic [7:0] base, input logic [23:0] kv, input bit done_pulse);
    int r;
    for (int d = 0; d <= eff; d++) begin
      @(negedge clk);
      bus.rc_done = done_pulse && (d == 1);
      r = (d < eff) ? d : eff - 1;
      chk("drive_col", 64'(bus.rc_lifm_column), 64'(col_of(base, r)));
      chk("drive_kidx", 64'(bus.rc_kidx), 64'(kv[r*8 +: 8]));
      chk("drive_no_enable", 64'(bus.rc_enable), 64'd0);
      chk("drive_ready", 64'(bus.word_ready), 64'd0);
    end
    @(negedge clk);
    bus.rc_done = 1'b0;
    chk("wait_col", 64'(bus.rc_lifm_column), 64'(col_of(base, eff - 1)));
    chk("wait_kidx", 64'(bus.rc_kidx), 64'(kv[(eff-1)*8 +: 8]));
    chk("wait_rsiz", 64'(bus.rc_rsiz), 64'(eff));
    chk("wait_busy", 64'(busy), 64'd1);
  endtask

  task automatic finish_done(input int extra, input logic [7:0] base, input int eff);
    repeat (extra) begin
      @(negedge clk);
      chk("wait_hold_col", 64'(bus.rc_lifm_column), 64'(col_of(base, eff - 1)));
      chk("wait_hold_ready", 64'(bus.word_ready), 64'd0);
    end
    @(negedge clk);
    bus.rc_done = 1'b1;
    @(negedge clk);
    bus.rc_done = 1'b0;
    check_idle("done");
  endtask

  initial begin
    bus.rsiz       = '0;
    bus.word_valid = 1'b0;
    bus.word_data  = '0;
    bus.word_kidx  = '0;
    bus.rc_done    = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 64'(bus.word_ready), 64'd0);
    chk("rst_enable", 64'(bus.rc_enable), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_col", 64'(bus.rc_lifm_column), 64'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check_idle("post_rst");

    // rsiz=2, words 0x01..0x08, kidx 5 and 9.
    feed(8, 8'h01, 2'd2, 2, 24'h000905, 1'b0, 1'b0);
    drive(2, 8'h01, 24'h000905, 1'b0);
    finish_done(0, 8'h01, 2);

    // rsiz=3 with gapped valid; rc_done pulsed in FILL and DRIVE must be ignored.
    feed(12, 8'h10, 2'd3, 3, 24'h332211, 1'b1, 1'b1);
    drive(3, 8'h10, 24'h332211, 1'b1);
    finish_done(0, 8'h10, 3);

    // rsiz below two clamps to two rows.
    feed(8, 8'h20, 2'd0, 2, 24'h004241, 1'b0, 1'b0);
    drive(2, 8'h20, 24'h004241, 1'b0);
    finish_done(0, 8'h20, 2);
    feed(8, 8'h30, 2'd1, 2, 24'h005251, 1'b0, 1'b0);
    drive(2, 8'h30, 24'h005251, 1'b0);
    finish_done(0, 8'h30, 2);

    // Reset during DRIVE aborts the partition.
    feed(12, 8'h40, 2'd3, 3, 24'h636261, 1'b0, 1'b0);
    @(negedge clk);
    chk("pre_abort_col", 64'(bus.rc_lifm_column), 64'(col_of(8'h40, 0)));
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("abort_col", 64'(bus.rc_lifm_column), 64'd0);
    chk("abort_kidx", 64'(bus.rc_kidx), 64'd0);
    chk("abort_rsiz", 64'(bus.rc_rsiz), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_ready", 64'(bus.word_ready), 64'd0);
    chk("abort_enable", 64'(bus.rc_enable), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_idle("post_abort");
    feed(8, 8'h70, 2'd2, 2, 24'h007271, 1'b0, 1'b0);
    drive(2, 8'h70, 24'h007271, 1'b0);
    finish_done(0, 8'h70, 2);

    // Back-to-back partitions with rc_done three cycles after the drive.
    feed(8, 8'h50, 2'd2, 2, 24'h00B0A0, 1'b0, 1'b0);
    drive(2, 8'h50, 24'h00B0A0, 1'b0);
    finish_done(2, 8'h50, 2);
    feed(12, 8'h60, 2'd3, 3, 24'hC3C2C1, 1'b0, 1'b0);
    drive(3, 8'h60, 24'hC3C2C1, 1'b0);
    finish_done(2, 8'h60, 3);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
